// File: rtl/accel_regs_pkg.sv
// Register map, reset values and SPI FSM encoding shared by the accelerometer
// responder and its helpers.
package accel_regs_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [7:0] RST_BW_RATE     = 8'h0A;
  localparam logic [7:0] RST_POWER_CTL   = 8'h00;
  localparam logic [7:0] RST_INT_ENABLE  = 8'h00;
  localparam logic [7:0] RST_DATA_FORMAT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } spi_state_e;

  function automatic logic is_writable(input logic [5:0] addr);
    return (addr == ADDR_BW_RATE) || (addr == ADDR_POWER_CTL) ||
           (addr == ADDR_INT_ENABLE) || (addr == ADDR_DATA_FORMAT);
  endfunction

  function automatic logic is_sample_addr(input logic [5:0] addr);
    return (addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-bit synchronizer chain for asynchronous SPI pins with rise/fall pulses.
// Edges are produced for the upper EDGE_W pins, levels for the lower LEVEL_W pins.
module spi_pin_sync #(
  parameter int               WIDTH   = 3,
  parameter int               STAGES  = 2,
  parameter int               EDGE_W  = 2,
  parameter int               LEVEL_W = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   pin,
  output logic [LEVEL_W-1:0] level,
  output logic [EDGE_W-1:0]  rise,
  output logic [EDGE_W-1:0]  fall
);

  logic [WIDTH-1:0]  chain_reg [STAGES];
  logic [EDGE_W-1:0] prev_reg;
  logic [WIDTH-1:0]  sync_now;
  logic [EDGE_W-1:0] edge_now;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) chain_reg[i] <= RST_VAL;
      prev_reg <= RST_VAL[WIDTH-1 -: EDGE_W];
    end else begin
      chain_reg[0] <= pin;
      for (int i = 1; i < STAGES; i++) chain_reg[i] <= chain_reg[i-1];
      prev_reg <= edge_now;
    end
  end

  assign sync_now = chain_reg[STAGES-1];
  assign edge_now = sync_now[WIDTH-1 -: EDGE_W];
  assign level    = sync_now[LEVEL_W-1:0];
  assign rise     = edge_now & ~prev_reg;
  assign fall     = ~edge_now & prev_reg;

endmodule

// File: rtl/accel_spi_responder.sv
// Mode-3 SPI responder emulating a 3-axis accelerometer: register file,
// coherent sample shadow with a pending slot, and auto-increment bursts.
module accel_spi_responder
  import accel_regs_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_csn,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic        data_ready_int
);

  logic [1:0] pin_level;
  logic [1:0] pin_rise;
  logic [1:0] pin_fall;
  logic       csn_level, csn_rise, csn_fall;
  logic       sclk_rise, sclk_fall, sdi_level;

  // Pin order {sclk, csn, sdi}: sclk needs only edges, sdi only its level.
  spi_pin_sync #(
    .WIDTH  (3),
    .STAGES (SYNC_STAGES),
    .EDGE_W (2),
    .LEVEL_W(2),
    .RST_VAL(3'b110)
  ) u_pin_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .pin    ({spi_sclk, spi_csn, spi_sdi}),
    .level  (pin_level),
    .rise   (pin_rise),
    .fall   (pin_fall)
  );

  assign csn_level = pin_level[1];
  assign sdi_level = pin_level[0];
  assign sclk_rise = pin_rise[1];
  assign sclk_fall = pin_fall[1];
  assign csn_rise  = pin_rise[0];
  assign csn_fall  = pin_fall[0];

  spi_state_e  state_reg, state_next;
  logic [2:0]  bit_cnt_reg;
  logic [6:0]  shift_in_reg;
  logic [7:0]  shift_out_reg;
  logic        sdo_reg, rw_reg, mb_reg, sample_read_reg;
  logic [5:0]  addr_reg;
  logic [7:0]  bw_rate_reg, power_ctl_reg, int_enable_reg, data_format_reg;
  logic [15:0] shadow_x_reg, shadow_y_reg, shadow_z_reg;
  logic [15:0] pend_x_reg, pend_y_reg, pend_z_reg;
  logic        pend_valid_reg, data_ready_reg, data_ready_int_reg;

  logic [7:0]  rx_byte, load_data;
  logic [5:0]  addr_next, load_addr;
  logic        cmd_done, byte_done, shift_en;

  assign rx_byte   = {shift_in_reg, sdi_level};
  assign addr_next = mb_reg ? addr_reg + 6'd1 : addr_reg;
  assign load_addr = cmd_done ? rx_byte[5:0] : addr_next;
  assign shift_en  = (state_reg == ST_DATA) && rw_reg && sclk_fall && !csn_rise;

  always_comb begin
    state_next = state_reg;
    cmd_done   = 1'b0;
    byte_done  = 1'b0;
    case (state_reg)
      ST_IDLE: if (csn_fall) state_next = ST_CMD;
      ST_CMD: begin
        if (sclk_rise && bit_cnt_reg == 3'd7) begin
          state_next = ST_DATA;
          cmd_done   = 1'b1;
        end
      end
      ST_DATA: if (sclk_rise && bit_cnt_reg == 3'd7) byte_done = 1'b1;
      default: state_next = ST_IDLE;
    endcase
    // CSN release aborts everything, including a byte finishing on the same clk.
    if (csn_rise) begin
      state_next = ST_IDLE;
      cmd_done   = 1'b0;
      byte_done  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    load_data = 8'h00;
    case (load_addr)
      ADDR_DEVID:       load_data = DEVID;
      ADDR_BW_RATE:     load_data = bw_rate_reg;
      ADDR_POWER_CTL:   load_data = power_ctl_reg;
      ADDR_INT_ENABLE:  load_data = int_enable_reg;
      ADDR_INT_SOURCE:  load_data = {data_ready_reg, 7'd0};
      ADDR_DATA_FORMAT: load_data = data_format_reg;
      ADDR_DATAX0:      load_data = shadow_x_reg[7:0];
      ADDR_DATAX1:      load_data = shadow_x_reg[15:8];
      ADDR_DATAY0:      load_data = shadow_y_reg[7:0];
      ADDR_DATAY1:      load_data = shadow_y_reg[15:8];
      ADDR_DATAZ0:      load_data = shadow_z_reg[7:0];
      ADDR_DATAZ1:      load_data = shadow_z_reg[15:8];
      default:          load_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_reg     <= 3'd0;
      shift_in_reg    <= 7'd0;
      shift_out_reg   <= 8'h00;
      sdo_reg         <= 1'b1;
      rw_reg          <= 1'b0;
      mb_reg          <= 1'b0;
      addr_reg        <= 6'd0;
      sample_read_reg <= 1'b0;
    end else begin
      if (csn_fall) begin
        bit_cnt_reg <= 3'd0;
      end else if (sclk_rise && state_reg != ST_IDLE) begin
        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
        shift_in_reg <= rx_byte[6:0];
      end

      if (cmd_done) begin
        rw_reg   <= rx_byte[7];
        mb_reg   <= rx_byte[6];
        addr_reg <= rx_byte[5:0];
      end else if (byte_done) begin
        addr_reg <= addr_next;
      end

      if (cmd_done || (byte_done && rw_reg)) shift_out_reg <= load_data;
      else if (shift_en)                     shift_out_reg <= {shift_out_reg[6:0], 1'b0};

      if (csn_rise || cmd_done) sdo_reg <= 1'b1;
      else if (shift_en)        sdo_reg <= shift_out_reg[7];

      // A sample byte counts as consumed once its MSB leaves on the pin.
      if (csn_rise || csn_fall)
        sample_read_reg <= 1'b0;
      else if (shift_en && bit_cnt_reg == 3'd0 && is_sample_addr(addr_reg))
        sample_read_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bw_rate_reg     <= RST_BW_RATE;
      power_ctl_reg   <= RST_POWER_CTL;
      int_enable_reg  <= RST_INT_ENABLE;
      data_format_reg <= RST_DATA_FORMAT;
    end else if (byte_done && !rw_reg && is_writable(addr_reg)) begin
      case (addr_reg)
        ADDR_BW_RATE:     bw_rate_reg     <= rx_byte;
        ADDR_POWER_CTL:   power_ctl_reg   <= rx_byte;
        ADDR_INT_ENABLE:  int_enable_reg  <= rx_byte;
        ADDR_DATA_FORMAT: data_format_reg <= rx_byte;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_x_reg       <= 16'd0;
      shadow_y_reg       <= 16'd0;
      shadow_z_reg       <= 16'd0;
      pend_x_reg         <= 16'd0;
      pend_y_reg         <= 16'd0;
      pend_z_reg         <= 16'd0;
      pend_valid_reg     <= 1'b0;
      data_ready_reg     <= 1'b0;
      data_ready_int_reg <= 1'b0;
    end else begin
      data_ready_int_reg <= data_ready_reg & int_enable_reg[7];
      if (csn_rise) begin
        // A strobe coinciding with CSN release is newer than any pending sample.
        if (sample_valid) begin
          shadow_x_reg   <= sample_x;
          shadow_y_reg   <= sample_y;
          shadow_z_reg   <= sample_z;
          data_ready_reg <= 1'b1;
        end else if (pend_valid_reg) begin
          shadow_x_reg   <= pend_x_reg;
          shadow_y_reg   <= pend_y_reg;
          shadow_z_reg   <= pend_z_reg;
          data_ready_reg <= 1'b1;
        end else if (sample_read_reg) begin
          data_ready_reg <= 1'b0;
        end
        pend_valid_reg <= 1'b0;
      end else if (sample_valid) begin
        if (csn_level) begin
          shadow_x_reg   <= sample_x;
          shadow_y_reg   <= sample_y;
          shadow_z_reg   <= sample_z;
          data_ready_reg <= 1'b1;
        end else begin
          pend_x_reg     <= sample_x;
          pend_y_reg     <= sample_y;
          pend_z_reg     <= sample_z;
          pend_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign spi_sdo_oe     = ~csn_level;
  assign spi_sdo        = (state_reg == ST_DATA && rw_reg) ? sdo_reg : 1'b1;
  assign data_ready_int = data_ready_int_reg;

endmodule

// File: tb/tb_accel_spi_responder.sv
// Scoreboarded bench: an SPI master issues transactions and pushes expected read
// bytes; a passive pin monitor decodes the bus and compares against the queue.
module tb_accel_spi_responder;

  localparam int T_HALF = 50;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_sclk = 1'b1;
  logic        spi_sdi = 1'b0;
  logic        spi_sdo, spi_sdo_oe, data_ready_int;
  logic [15:0] sample_x = 16'd0, sample_y = 16'd0, sample_z = 16'd0;
  logic        sample_valid = 1'b0;

  always #5 clk = ~clk;

  accel_spi_responder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .spi_csn       (spi_csn),
    .spi_sclk      (spi_sclk),
    .spi_sdi       (spi_sdi),
    .spi_sdo       (spi_sdo),
    .spi_sdo_oe    (spi_sdo_oe),
    .sample_x      (sample_x),
    .sample_y      (sample_y),
    .sample_z      (sample_z),
    .sample_valid  (sample_valid),
    .data_ready_int(data_ready_int)
  );

  int n_cmp = 0;
  int n_mis = 0;
  bit mon_en = 1'b1;

  typedef struct {
    logic [7:0] val;
    int         addr;
  } exp_t;
  exp_t exp_q[$];

  // Reference model of the sensor as seen by a bus master.
  logic [7:0]  m_bw = 8'h0A, m_pwr = 8'h00, m_inten = 8'h00, m_fmt = 8'h00;
  logic [15:0] m_sh[3];
  logic [15:0] m_pend[3];
  bit          m_pend_v = 1'b0, m_dr = 1'b0, m_touch = 1'b0;
  logic [7:0]  wbuf[8];
  int          wlist[6] = '{'h2C, 'h2D, 'h2E, 'h31, 'h00, 'h35};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(input int a);
    int k;
    k = a - 'h32;
    case (a)
      'h00: return 8'hE5;
      'h2C: return m_bw;
      'h2D: return m_pwr;
      'h2E: return m_inten;
      'h30: return {m_dr, 7'd0};
      'h31: return m_fmt;
      'h32, 'h33, 'h34, 'h35, 'h36, 'h37:
        return (k % 2 == 1) ? m_sh[k / 2][15:8] : m_sh[k / 2][7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_write(input int a, input logic [7:0] d);
    case (a)
      'h2C: m_bw = d;
      'h2D: m_pwr = d;
      'h2E: m_inten = d;
      'h31: m_fmt = d;
      default: ;
    endcase
  endtask

  task automatic m_reset();
    m_bw = 8'h0A; m_pwr = 8'h00; m_inten = 8'h00; m_fmt = 8'h00;
    for (int i = 0; i < 3; i++) begin m_sh[i] = 16'd0; m_pend[i] = 16'd0; end
    m_pend_v = 1'b0; m_dr = 1'b0; m_touch = 1'b0;
  endtask

  task automatic m_cs_rise();
    if (m_pend_v) begin
      m_sh = m_pend;
      m_dr = 1'b1;
      m_pend_v = 1'b0;
    end else if (m_touch) begin
      m_dr = 1'b0;
    end
    m_touch = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b0;
      spi_sdi  = b[7-i];
      #(T_HALF);
      spi_sclk = 1'b1;
      #(T_HALF);
    end
  endtask

  task automatic cs_low();
    spi_csn = 1'b0;
    #(2 * T_HALF);
    check("sdo_oe_active", 32'(spi_sdo_oe), 32'd1);
  endtask

  task automatic cs_high();
    #(T_HALF);
    spi_csn = 1'b1;
    m_cs_rise();
    #(4 * T_HALF);
  endtask

  task automatic spi_read(input int addr, input bit mb, input int n);
    int a;
    logic [7:0] cmd;
    a = addr;
    cmd = {1'b1, mb, 6'(addr)};
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{m_read(a), a});
      if (a >= 'h32 && a <= 'h37) m_touch = 1'b1;
      if (mb) a = (a + 1) % 64;
    end
    $display("txn read  addr=0x%02h mb=%0d bytes=%0d", addr, mb, n);
    cs_low();
    spi_bits(cmd, 8);
    for (int i = 0; i < n; i++) spi_bits(8'h00, 8);
    cs_high();
  endtask

  task automatic spi_write(input int addr, input bit mb, input int n);
    int a;
    logic [7:0] cmd;
    a = addr;
    cmd = {1'b0, mb, 6'(addr)};
    $display("txn write addr=0x%02h mb=%0d bytes=%0d first=0x%02h", addr, mb, n, wbuf[0]);
    cs_low();
    spi_bits(cmd, 8);
    for (int i = 0; i < n; i++) begin
      spi_bits(wbuf[i], 8);
      m_write(a, wbuf[i]);
      if (mb) a = (a + 1) % 64;
    end
    cs_high();
  endtask

  // Returns on the falling clk edge right after the strobe cycle.
  task automatic inject(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sample_x = x; sample_y = y; sample_z = z;
    sample_valid = 1'b1;
    if (spi_csn) begin
      m_sh[0] = x; m_sh[1] = y; m_sh[2] = z;
      m_dr = 1'b1;
    end else begin
      m_pend[0] = x; m_pend[1] = y; m_pend[2] = z;
      m_pend_v = 1'b1;
    end
    $display("txn sample x=0x%04h y=0x%04h z=0x%04h csn=%0d", x, y, z, spi_csn);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Passive monitor: decodes the bus from the pins, compares every read byte.
  initial begin : monitor
    int cnt;
    logic [7:0] cmd, rx;
    exp_t e;
    cnt = 0; cmd = 8'h00; rx = 8'h00;
    forever begin
      @(posedge spi_sclk or posedge spi_csn);
      if (spi_csn) begin
        cnt = 0;
      end else begin
        if (cnt < 8) cmd = {cmd[6:0], spi_sdi};
        else         rx  = {rx[6:0], spi_sdo};
        cnt++;
        if (cnt >= 16 && cnt % 8 == 0 && cmd[7] && mon_en) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL unexpected_read_byte: got 0x%02h expected none", rx);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("read_addr_%02h", e.addr), 32'(rx), 32'(e.val));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(20_000_000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int a, n, op;
    bit mb;
    m_reset();

    repeat (4) @(negedge clk);
    check("rst_sdo", 32'(spi_sdo), 32'd1);
    check("rst_sdo_oe", 32'(spi_sdo_oe), 32'd0);
    check("rst_int", 32'(data_ready_int), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_sdo_oe", 32'(spi_sdo_oe), 32'd0);

    // DEVID single-byte read
    spi_read('h00, 1'b0, 1);
    check("sdo_oe_after_cs", 32'(spi_sdo_oe), 32'd0);
    spi_read('h2C, 1'b0, 1);
    spi_read('h30, 1'b0, 1);

    // Sample burst read and DATA_READY clear
    inject(16'h0123, 16'hFF00, 16'h8001);
    spi_read('h30, 1'b0, 1);
    spi_read('h32, 1'b1, 6);
    spi_read('h30, 1'b0, 1);

    // Register writes, including a dropped write to DEVID
    wbuf[0] = 8'h08; spi_write('h2D, 1'b0, 1);
    spi_read('h2D, 1'b0, 1);
    wbuf[0] = 8'h12; spi_write('h00, 1'b0, 1);
    spi_read('h00, 1'b0, 1);

    // Sample arriving mid-burst lands in the pending slot
    inject(16'h1111, 16'h2222, 16'h3333);
    fork
      spi_read('h32, 1'b1, 6);
      begin
        #(2 * T_HALF * 8 * 3);
        inject(16'h7FFF, 16'h1234, 16'h5678);
      end
    join
    spi_read('h30, 1'b0, 1);
    spi_read('h32, 1'b1, 2);
    spi_read('h30, 1'b0, 1);

    // Interrupt latency and clear-on-read
    wbuf[0] = 8'h80; spi_write('h2E, 1'b0, 1);
    check("int_before_sample", 32'(data_ready_int), 32'd0);
    inject(16'h0A0B, 16'h0C0D, 16'h0E0F);
    check("int_1clk_after_strobe", 32'(data_ready_int), 32'd0);
    @(negedge clk);
    check("int_2clk_after_strobe", 32'(data_ready_int), 32'd1);
    spi_read('h32, 1'b1, 6);
    check("int_after_data_read", 32'(data_ready_int), 32'd0);

    // Abort after five bits of a data byte
    $display("txn abort write addr=0x31 after 5 data bits");
    cs_low();
    spi_bits(8'h31, 8);
    spi_bits(8'hFF, 5);
    #(T_HALF);
    spi_csn = 1'b1;
    #(4 * T_HALF);
    spi_read('h31, 1'b0, 1);
    spi_read('h00, 1'b0, 1);

    // Randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      op = int'($urandom_range(0, 3));
      mb = 1'($urandom_range(0, 1));
      case (op)
        0: inject(16'($urandom), 16'($urandom), 16'($urandom));
        1: begin
          a = int'($urandom_range(0, 63));
          n = int'($urandom_range(1, 4));
          spi_read(a, mb, n);
        end
        2: begin
          a = wlist[$urandom_range(0, 5)];
          n = int'($urandom_range(1, 3));
          for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
          spi_write(a, mb, n);
        end
        default: begin
          a = int'($urandom_range('h2C, 'h37));
          n = int'($urandom_range(1, 8));
          spi_read(a, 1'b1, n);
        end
      endcase
      #(100);
      check("int_random", 32'(data_ready_int), 32'(m_dr & m_inten[7]));
    end

    // Asynchronous reset in the middle of a read
    wbuf[0] = 8'h80; spi_write('h2E, 1'b0, 1);
    inject(16'h0000, 16'hAAAA, 16'h5555);
    #(100);
    mon_en = 1'b0;
    $display("txn read  addr=0x32 interrupted by reset");
    cs_low();
    spi_bits(8'hF2, 8);
    spi_bits(8'h00, 3);
    check("pre_rst_sdo", 32'(spi_sdo), 32'd0);
    check("pre_rst_int", 32'(data_ready_int), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_sdo", 32'(spi_sdo), 32'd1);
    check("mid_rst_sdo_oe", 32'(spi_sdo_oe), 32'd0);
    check("mid_rst_int", 32'(data_ready_int), 32'd0);
    spi_csn = 1'b1;
    #(4 * T_HALF);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    #(2 * T_HALF);
    mon_en = 1'b1;
    spi_read('h2C, 1'b0, 1);
    spi_read('h2E, 1'b0, 1);
    spi_read('h32, 1'b1, 2);
    spi_read('h00, 1'b0, 1);

    #(200);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
